// File: rtl/padder_feeder_pkg.sv
// Shared widths, FSM states and word-building helpers for the padder feeder.
package padder_feeder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    COLLECT,
    LAST_Q,
    DONE
  } state_e;

  // Keep the first cnt bytes of a big-endian word and zero the rest.
  function automatic logic [WORD_W-1:0] last_word(input logic [WORD_W-1:0] data,
                                                  input logic [1:0]        cnt);
    case (cnt)
      2'd0:    return '0;
      2'd1:    return {data[31:24], 24'h0};
      2'd2:    return {data[31:16], 16'h0};
      default: return {data[31:8], 8'h0};
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] data,
                                                 input logic [1:0]        idx,
                                                 input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = data;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/padder_feeder_word_slot.sv
// One-entry output register towards the padder: load on demand, drained when not buffer_full.
module feeder_word_slot
  import padder_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              last_i,
  input  logic [1:0]        num_i,
  input  logic              full_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  output logic              last_o,
  output logic [1:0]        num_o,
  output logic              take_o
);

  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              last_q;
  logic [1:0]        num_q;

  assign take_o  = valid_q && !full_i;
  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign num_o   = num_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      num_q   <= '0;
    end else if (load_i) begin
      word_q  <= word_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
      num_q   <= num_i;
    end else if (take_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/padder_feeder.sv
// Byte-stream to 32-bit big-endian word feeder for the padder, with end-of-message encoding.
module padder_feeder
  import padder_feeder_pkg::*;
#(
  parameter int unsigned MSG_LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BYTE_W-1:0]    byte_in,
  input  logic                 byte_valid,
  input  logic                 byte_last,
  output logic                 byte_ready,
  input  logic                 flush,
  input  logic                 next_msg,
  output logic [WORD_W-1:0]    in,
  output logic                 in_ready,
  output logic                 is_last,
  output logic [1:0]           byte_num,
  input  logic                 buffer_full,
  output logic                 done,
  output logic [MSG_LEN_W-1:0] msg_bytes
);

  state_e                state_q, state_d;
  logic [1:0]            asm_cnt_q, asm_cnt_d;
  logic [WORD_W-1:0]     asm_data_q, asm_data_d;
  logic                  pend_empty_q, pend_empty_d;
  logic [MSG_LEN_W-1:0]  msg_bytes_q, msg_bytes_d;
  logic                  byte_ready_q, byte_ready_d;

  logic                  load;
  logic [WORD_W-1:0]     load_word;
  logic                  load_last;
  logic [1:0]            load_num;
  logic                  take;
  logic                  slot_free;
  logic                  in_ready_d;
  logic                  byte_take;
  logic [WORD_W-1:0]     merged;
  logic [1:0]            k;

  feeder_word_slot u_slot (
    .clk     (clk),
    .rst     (reset),
    .load_i  (load),
    .word_i  (load_word),
    .last_i  (load_last),
    .num_i   (load_num),
    .full_i  (buffer_full),
    .word_o  (in),
    .valid_o (in_ready),
    .last_o  (is_last),
    .num_o   (byte_num),
    .take_o  (take)
  );

  assign byte_ready = byte_ready_q;
  assign done       = (state_q == DONE);
  assign msg_bytes  = msg_bytes_q;
  assign byte_take  = byte_valid && byte_ready_q;
  assign slot_free  = !in_ready || take;
  assign merged     = put_byte(asm_data_q, asm_cnt_q, byte_in);
  assign k          = asm_cnt_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    asm_cnt_d    = asm_cnt_q;
    asm_data_d   = asm_data_q;
    pend_empty_d = pend_empty_q;
    msg_bytes_d  = msg_bytes_q;
    load         = 1'b0;
    load_word    = '0;
    load_last    = 1'b0;
    load_num     = '0;
    case (state_q)
      COLLECT: begin
        if (byte_take) begin
          msg_bytes_d = msg_bytes_q + MSG_LEN_W'(1);
          if (asm_cnt_q == 2'd3) begin
            // A fourth byte is only accepted while the slot is empty.
            load       = 1'b1;
            load_word  = merged;
            asm_cnt_d  = '0;
            asm_data_d = '0;
            if (byte_last || flush) begin
              pend_empty_d = 1'b1;
              state_d      = LAST_Q;
            end
          end else if (byte_last || flush) begin
            state_d = LAST_Q;
            if (slot_free) begin
              load       = 1'b1;
              load_word  = last_word(merged, k);
              load_last  = 1'b1;
              load_num   = k;
              asm_cnt_d  = '0;
              asm_data_d = '0;
            end else begin
              asm_data_d = merged;
              asm_cnt_d  = k;
            end
          end else begin
            asm_data_d = merged;
            asm_cnt_d  = k;
          end
        end else if (flush) begin
          state_d = LAST_Q;
          if (slot_free) begin
            load       = 1'b1;
            load_word  = last_word(asm_data_q, asm_cnt_q);
            load_last  = 1'b1;
            load_num   = asm_cnt_q;
            asm_cnt_d  = '0;
            asm_data_d = '0;
          end
        end
      end
      LAST_Q: begin
        if (in_ready && is_last) begin
          if (take) state_d = DONE;
        end else if (slot_free) begin
          // Covers both a partial tail and the empty word after an exact multiple of 4.
          load         = 1'b1;
          load_word    = last_word(asm_data_q, asm_cnt_q);
          load_last    = 1'b1;
          load_num     = asm_cnt_q;
          asm_cnt_d    = '0;
          asm_data_d   = '0;
          pend_empty_d = 1'b0;
        end
      end
      DONE: begin
        if (next_msg) begin
          state_d     = COLLECT;
          msg_bytes_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign in_ready_d   = load || (in_ready && !take);
  assign byte_ready_d = (state_d == COLLECT) && !pend_empty_d &&
                        ((asm_cnt_d != 2'd3) || !in_ready_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      asm_cnt_q    <= '0;
      asm_data_q   <= '0;
      pend_empty_q <= 1'b0;
      msg_bytes_q  <= '0;
      byte_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_data_q   <= asm_data_d;
      pend_empty_q <= pend_empty_d;
      msg_bytes_q  <= msg_bytes_d;
      byte_ready_q <= byte_ready_d;
    end
  end

endmodule

// File: tb/tb_padder_feeder.sv
// Scoreboard bench for padder_feeder: message-level reference model vs. words taken by the padder.
module tb_padder_feeder;

  localparam int unsigned MLW = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     byte_in = '0;
  logic           byte_valid = 1'b0;
  logic           byte_last = 1'b0;
  logic           byte_ready;
  logic           flush = 1'b0;
  logic           next_msg = 1'b0;
  logic [31:0]    in_w;
  logic           in_ready;
  logic           is_last;
  logic [1:0]     byte_num;
  logic           buffer_full = 1'b0;
  logic           done;
  logic [MLW-1:0] msg_bytes;

  typedef struct {
    logic [31:0] w;
    logic        l;
    logic [1:0]  n;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         bf_hold = 1'b0;
  bit         bf_rand = 1'b0;
  bit         gaps = 1'b1;

  always #5 clk = ~clk;

  padder_feeder #(.MSG_LEN_W(MLW)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .next_msg    (next_msg),
    .in          (in_w),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .done        (done),
    .msg_bytes   (msg_bytes)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full 4-byte groups are plain words; the tail (0..3 bytes) is the last word.
  task automatic push_model();
    int unsigned n    = msg.size();
    int unsigned full = n / 4;
    int unsigned rem  = n % 4;
    exp_t e;
    for (int unsigned i = 0; i < full; i++) begin
      e.w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      e.l = 1'b0;
      e.n = 2'd0;
      exp_q.push_back(e);
    end
    e.w = '0;
    for (int unsigned j = 0; j < rem; j++)
      e.w = e.w | (32'(msg[4*full+j]) << (24 - 8*j));
    e.l = 1'b1;
    e.n = 2'(rem);
    exp_q.push_back(e);
  endtask

  // buffer_full driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      buffer_full = bf_hold || (bf_rand && ($urandom_range(0, 2) == 0));
    end
  end

  // Monitor: compares every word the padder takes and checks stability while stalled.
  initial begin
    logic stall;
    exp_t held;
    exp_t e;
    stall = 1'b0;
    held.w = '0; held.l = 1'b0; held.n = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_in_ready", 32'(in_ready), 32'd1);
          chk("hold_in", in_w, held.w);
          chk("hold_is_last", 32'(is_last), 32'(held.l));
          chk("hold_byte_num", 32'(byte_num), 32'(held.n));
        end
        if (in_ready && !buffer_full) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got %0h expected no word at %0t", in_w, $time);
          end else begin
            e = exp_q.pop_front();
            chk("word_in", in_w, e.w);
            chk("word_is_last", 32'(is_last), 32'(e.l));
            chk("word_byte_num", 32'(byte_num), 32'(e.n));
          end
        end
        stall  = in_ready && buffer_full;
        held.w = in_w;
        held.l = is_last;
        held.n = byte_num;
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input bit l, input bit f);
    int t = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    while (!byte_ready && t < 1000) begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      byte_last  = 1'b0;
      flush      = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    byte_last  = l;
    flush      = f;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    flush      = 1'b0;
  endtask

  // mode 0: byte_last on final byte, 1: flush with final byte, 2: flush afterwards, 3: no end
  task automatic send_msg(input int mode);
    int n = int'(msg.size());
    if (mode != 3) push_model();
    for (int i = 0; i < n; i++)
      drive_byte(msg[i], (i == n-1) && mode == 0, (i == n-1) && mode == 1);
    if (mode == 2) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  task automatic finish_msg(input int n, input bit done_test);
    int t = 0;
    while (!done && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done", 32'(done), 32'd1);
    chk("msg_bytes", msg_bytes, 32'(n));
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    chk("byte_ready_in_done", 32'(byte_ready), 32'd0);
    if (done_test) begin
      byte_valid = 1'b1;
      byte_in    = 8'hEE;
      flush      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("done_ignore_in_ready", 32'(in_ready), 32'd0);
      chk("done_ignore_msg_bytes", msg_bytes, 32'(n));
      chk("done_ignore_done", 32'(done), 32'd1);
      byte_valid = 1'b0;
      flush      = 1'b0;
    end
    next_msg = 1'b1;
    @(posedge clk); #1;
    next_msg = 1'b0;
    chk("next_msg_done", 32'(done), 32'd0);
    chk("next_msg_msg_bytes", msg_bytes, 32'd0);
    chk("next_msg_byte_ready", 32'(byte_ready), 32'd1);
  endtask

  initial begin
    int n;
    int mode;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in", in_w, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_is_last", 32'(is_last), 32'd0);
    chk("rst_byte_num", 32'(byte_num), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_msg_bytes", msg_bytes, 32'd0);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("byte_ready_after_release", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    chk("byte_ready_first_cycle", 32'(byte_ready), 32'd1);

    // Empty message by flush
    msg.delete();
    send_msg(2);
    finish_msg(0, 1'b0);

    // Seven bytes, last on CD
    msg = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hAB, 8'hCD};
    send_msg(0);
    finish_msg(7, 1'b0);

    // Eight bytes, last completes a word -> trailing empty word; then DONE ignores input
    msg = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hAB, 8'hCD, 8'hEF};
    send_msg(0);
    finish_msg(8, 1'b1);

    msg = '{8'h01, 8'h02};
    send_msg(0);
    finish_msg(2, 1'b0);

    // 72 bytes with a 10-cycle buffer_full stall mid-message
    msg.delete();
    for (int i = 0; i < 72; i++) msg.push_back(8'($urandom));
    gaps = 1'b0;
    fork
      send_msg(0);
      begin
        repeat (20) @(posedge clk);
        bf_hold = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("stall_byte_ready", 32'(byte_ready), 32'd0);
        chk("stall_in_ready", 32'(in_ready), 32'd1);
        bf_hold = 1'b0;
      end
    join
    gaps = 1'b1;
    finish_msg(72, 1'b0);

    // Reset with a word in the slot and two bytes assembled
    bf_hold = 1'b1;
    @(posedge clk); #1;
    msg = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_msg(3);
    reset = 1'b1;
    #1;
    chk("midrst_in", in_w, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_is_last", 32'(is_last), 32'd0);
    chk("midrst_byte_num", 32'(byte_num), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_msg_bytes", msg_bytes, 32'd0);
    chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    bf_hold = 1'b0;
    @(posedge clk); #1;
    msg = '{8'h5A, 8'h6B, 8'h7C};
    send_msg(1);
    finish_msg(3, 1'b0);

    // Randomised messages with random back-pressure
    bf_rand = 1'b1;
    for (int m = 0; m < 30; m++) begin
      n = $urandom_range(0, 13);
      mode = (n == 0) ? 2 : $urandom_range(0, 2);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      send_msg(mode);
      finish_msg(n, 1'b0);
    end
    bf_rand = 1'b0;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
